// File: rtl/spi_req_arbiter_if.sv
// spi_req_arbiter_if: requester-side and SPI-master-side signals of the arbiter
interface spi_req_arbiter_if #(parameter int NREQ = 2);
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      done;
  logic [32*NREQ-1:0]   req_addr;
  logic [16*NREQ-1:0]   req_tx_data;
  logic [32*NREQ-1:0]   req_clk_div;
  logic                 err;
  logic [15:0]          rx_data;
  logic                 busy;
  logic [15:0]          master_rx_data;
  logic                 enable;
  logic [31:0]          addr;
  logic [15:0]          tx_data;
  logic [31:0]          clk_div;
  modport slave (
    input  req, req_addr, req_tx_data, req_clk_div, busy, master_rx_data,
    output gnt, done, err, rx_data, enable, addr, tx_data, clk_div
  );
  modport master (
    output req, req_addr, req_tx_data, req_clk_div, busy, master_rx_data,
    input  gnt, done, err, rx_data, enable, addr, tx_data, clk_div
  );
endinterface

// File: rtl/spi_req_arbiter.sv
// spi_req_arbiter: round-robin sharing of one SPI master with a start-busy timeout
module spi_req_arbiter #(
  parameter int NREQ      = 2,
  parameter int START_TMO = 64
) (
  input logic clk_150MHz_i,
  input logic reset,
  spi_req_arbiter_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_BUSY = 2'd1;
  localparam logic [1:0] WAIT_DONE = 2'd2;
  logic [1:0]      r_state;
  logic [IW-1:0]   r_rr, r_own, w_win;
  logic            w_found;
  logic [15:0]     r_cnt;
  logic [NREQ-1:0] r_gnt, r_done;
  logic            r_err, r_en;
  logic [31:0]     r_addr, r_clk_div;
  logic [15:0]     r_tx, r_rx;
  // first set request at or after the rr pointer, wrapping
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && bus.req[(int'(r_rr) + k) % NREQ]) begin
        w_found = 1'b1;
        w_win   = IW'((int'(r_rr) + k) % NREQ);
      end
    end
  end
  always_ff @(posedge clk_150MHz_i) begin
    if (reset) begin
      r_state   <= IDLE;
      r_rr      <= '0;
      r_own     <= '0;
      r_cnt     <= '0;
      r_gnt     <= '0;
      r_done    <= '0;
      r_err     <= 1'b0;
      r_en      <= 1'b0;
      r_addr    <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_clk_div <= 32'd1;
    end else begin
      r_gnt  <= '0;
      r_en   <= 1'b0;
      r_done <= '0;
      r_err  <= 1'b0;
      if (r_state == IDLE) begin
        if (!bus.busy && w_found) begin
          r_gnt     <= NREQ'(1) << w_win;
          r_en      <= 1'b1;
          r_addr    <= bus.req_addr[32*int'(w_win) +: 32];
          r_tx      <= bus.req_tx_data[16*int'(w_win) +: 16];
          r_clk_div <= bus.req_clk_div[32*int'(w_win) +: 32];
          r_own     <= w_win;
          r_rr      <= (w_win == IW'(NREQ-1)) ? '0 : w_win + 1'b1;
          r_cnt     <= '0;
          r_state   <= WAIT_BUSY;
        end
      end else if (r_state == WAIT_BUSY) begin
        if (bus.busy) begin
          r_state <= WAIT_DONE;
        end else if (r_cnt == 16'(START_TMO-1)) begin
          r_done  <= NREQ'(1) << r_own;
          r_err   <= 1'b1;
          r_state <= IDLE;
        end else begin
          r_cnt <= r_cnt + 16'd1;
        end
      end else if (!bus.busy) begin
        r_rx    <= bus.master_rx_data;
        r_done  <= NREQ'(1) << r_own;
        r_state <= IDLE;
      end
    end
  end
  assign bus.gnt     = r_gnt;
  assign bus.done    = r_done;
  assign bus.err     = r_err;
  assign bus.enable  = r_en;
  assign bus.addr    = r_addr;
  assign bus.tx_data = r_tx;
  assign bus.clk_div = r_clk_div;
  assign bus.rx_data = r_rx;
endmodule

// File: tb/tb_spi_req_arbiter.sv
// tb_spi_req_arbiter: directed and randomized transfers against a round-robin reference model
module tb_spi_req_arbiter;
  localparam int NREQ = 2;
  localparam int TMO  = 64;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  int rr = 0;
  logic [15:0] exp_rx = '0;
  logic [31:0] a [NREQ];
  logic [31:0] c [NREQ];
  logic [15:0] t [NREQ];
  spi_req_arbiter_if #(.NREQ(NREQ)) bus ();
  spi_req_arbiter #(.NREQ(NREQ), .START_TMO(TMO)) dut (
    .clk_150MHz_i(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic int pick(input logic [NREQ-1:0] r);
    for (int k = 0; k < NREQ; k++)
      if (r[(rr + k) % NREQ]) return (rr + k) % NREQ;
    return -1;
  endfunction
  task automatic load(input int s, input logic [31:0] av, input logic [15:0] tv, input logic [31:0] cv);
    a[s] = av; t[s] = tv; c[s] = cv;
    bus.req_addr[32*s +: 32]    = av;
    bus.req_tx_data[16*s +: 16] = tv;
    bus.req_clk_div[32*s +: 32] = cv;
  endtask
  task automatic do_reset();
    bus.busy = 1'b0;
    bus.req  = '0;
    reset    = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_enable", bus.enable, 0);
    chk("rst_done_err", {bus.done, bus.err}, 0);
    chk("rst_addr", bus.addr, 0);
    chk("rst_tx", bus.tx_data, 0);
    chk("rst_rx", bus.rx_data, 0);
    chk("rst_clk_div", bus.clk_div, 1);
    reset  = 1'b0;
    rr     = 0;
    exp_rx = '0;
  endtask
  // Waits for the grant, plays the SPI master, and returns at the negedge where done shows.
  task automatic txn(input int bound, input int dly, input int len, input logic [15:0] rxw,
                     input logic [NREQ-1:0] raise, input bit drop, input bit tmo);
    int w;
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < bound && !seen; k++) begin
      @(negedge clk);
      if (bus.enable === 1'b1) seen = 1'b1;
      else chk("idle_done", {bus.done, bus.err}, 0);
    end
    chk("enable_seen", 32'(seen), 1);
    if (!seen) return;
    w = pick(bus.req);
    chk("gnt", bus.gnt, (w < 0) ? 0 : (1 << w));
    if (w < 0) w = 0;
    rr = (w + 1) % NREQ;
    chk("addr", bus.addr, a[w]);
    chk("tx_data", bus.tx_data, 32'(t[w]));
    chk("clk_div", bus.clk_div, c[w]);
    if (drop) bus.req[w] = 1'b0;
    if (tmo) begin
      bus.master_rx_data = 16'($urandom);
      for (int k = 1; k < TMO; k++) begin
        @(negedge clk);
        if (k == 1) chk("tmo_pulse_end", {bus.gnt, bus.enable}, 0);
        if (k == TMO/2) bus.req = bus.req | raise;
        chk("tmo_early_done", {bus.done, bus.err}, 0);
      end
      @(negedge clk);
      chk("tmo_done", bus.done, 1 << w);
      chk("tmo_err", bus.err, 1);
      chk("tmo_rx_kept", bus.rx_data, 32'(exp_rx));
      return;
    end
    for (int k = 1; k <= dly; k++) begin
      @(negedge clk);
      if (k == 1) chk("pulse_end", {bus.gnt, bus.enable}, 0);
    end
    bus.busy = 1'b1;
    bus.req  = bus.req | raise;
    repeat (len) @(negedge clk);
    chk("busy_no_done", {bus.done, bus.err, bus.enable}, 0);
    bus.master_rx_data = rxw;
    bus.busy = 1'b0;
    exp_rx = rxw;
    @(negedge clk);
    chk("done", bus.done, 1 << w);
    chk("done_err", bus.err, 0);
    chk("rx_data", bus.rx_data, 32'(rxw));
    chk("addr_stable", bus.addr, a[w]);
  endtask
  initial begin
    bus.req = '0; bus.busy = 1'b0; bus.master_rx_data = '0;
    bus.req_addr = '0; bus.req_tx_data = '0; bus.req_clk_div = '0;
    for (int s = 0; s < NREQ; s++) load(s, $urandom, 16'($urandom), $urandom_range(1, 255));
    do_reset();
    // single transfer from slot 0
    load(0, 32'h10, 16'hA500, 32'd4);
    bus.req = 2'b01;
    txn(3, 2, 20, 16'h1234, 2'b00, 1'b1, 1'b0);
    // both requesters held: alternating grants from a fresh pointer
    do_reset();
    bus.req = 2'b11;
    for (int n = 0; n < 4; n++) begin
      txn((n == 0) ? 3 : 1, 1 + n, 3 + 2*n, 16'($urandom), 2'b00, 1'b0, 1'b0);
      chk("order", bus.done, (n % 2 == 0) ? 2'b01 : 2'b10);
    end
    bus.req = '0;
    // master never raises busy
    bus.req = 2'b01;
    txn(3, 0, 0, 16'h0, 2'b00, 1'b1, 1'b1);
    bus.req = 2'b10;
    txn(1, 3, 7, 16'($urandom), 2'b00, 1'b1, 1'b0);
    // master busy while idle blocks the grant
    @(negedge clk);
    bus.busy = 1'b1;
    bus.req  = 2'b01;
    repeat (8) begin
      @(negedge clk);
      chk("busy_block", {bus.gnt, bus.enable}, 0);
    end
    bus.busy = 1'b0;
    txn(1, 2, 5, 16'($urandom), 2'b00, 1'b1, 1'b0);
    // late request waits for the current transfer
    bus.req = 2'b01;
    txn(3, 2, 10, 16'($urandom), 2'b10, 1'b1, 1'b0);
    txn(1, 2, 6, 16'($urandom), 2'b00, 1'b1, 1'b0);
    // reset during the transfer phase
    bus.req = 2'b01;
    @(negedge clk);
    chk("r5_enable", bus.enable, 1);
    bus.req = '0;
    repeat (2) @(negedge clk);
    bus.busy = 1'b1;
    repeat (5) @(negedge clk);
    do_reset();
    repeat (5) begin
      @(negedge clk);
      chk("r5_no_done", {bus.done, bus.err, bus.enable}, 0);
    end
    bus.req = 2'b10;
    txn(3, 1, 4, 16'($urandom), 2'b00, 1'b1, 1'b0);
    // randomized traffic
    for (int n = 0; n < 12; n++) begin
      for (int s = 0; s < NREQ; s++) load(s, $urandom, 16'($urandom), $urandom);
      if (bus.req == '0) bus.req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      txn(3, $urandom_range(1, 5), $urandom_range(1, 30), 16'($urandom),
          NREQ'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0));
    end
    bus.req = '0;
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
